// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V funct3 codes for
// loads/stores, the FSM state encoding and funct3 legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } lsu_state_e;

  // Loads accept signed and unsigned byte/half plus word
  function automatic logic load_f3_ok(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Stores only have byte, half and word forms
  function automatic logic store_f3_ok(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// Combinational byte-lane logic: extracts and extends load data from a
// memory word, and merges store data into a word for read-modify-write.
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

  // Load extraction with sign or zero extension
  always_comb begin
    o_load = '0;
    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_W:    o_load = i_word;
      F3_BU:   o_load = {24'h000000, w_byte};
      F3_HU:   o_load = {16'h0000, w_half};
      default: o_load = '0;
    endcase
  end

  // Store merge: replace the addressed lane(s) of the read word
  always_comb begin
    o_merged = i_word;
    case (i_funct3)
      F3_B: begin
        case (i_addr_lo)
          2'd0:    o_merged = {i_word[31:8], i_wdata[7:0]};
          2'd1:    o_merged = {i_word[31:16], i_wdata[7:0], i_word[7:0]};
          2'd2:    o_merged = {i_word[31:24], i_wdata[7:0], i_word[15:0]};
          default: o_merged = {i_wdata[7:0], i_word[23:0]};
        endcase
      end
      F3_H: begin
        if (i_addr_lo[1]) o_merged = {i_wdata[15:0], i_word[15:0]};
        else              o_merged = {i_word[31:16], i_wdata[15:0]};
      end
      F3_W:    o_merged = i_wdata;
      default: o_merged = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-only memory.
// Loads extract/extend bytes and halves; SB/SH use read-modify-write.
// Optional macro LSU_MISALIGN_CHK_EN turns misaligned half/word accesses
// into errors; without it the low address bits are ignored for them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            mem_read,
  output logic            mem_write,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [XLEN-1:0] ADDR_LIMIT = XLEN'(MEM_WORDS * 4);

  lsu_state_e      r_state;
  logic            r_we;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_merge;
  logic            r_rsp_valid;
  logic            r_rsp_err;
  logic [XLEN-1:0] r_rsp_rdata;

  logic            w_f3_bad;
  logic            w_range_bad;
  logic            w_misalign;
  logic            w_req_err;
  logic [XLEN-1:0] w_word;
  logic [XLEN-1:0] w_load;
  logic [XLEN-1:0] w_merged;

  assign w_f3_bad    = req_we ? !store_f3_ok(req_funct3) : !load_f3_ok(req_funct3);
  assign w_range_bad = (req_addr >= ADDR_LIMIT);

`ifdef LSU_MISALIGN_CHK_EN
  assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_req_err = w_f3_bad || w_range_bad || w_misalign;

  // Loads extract from live read data; stores merge into the buffered word
  assign w_word = (r_state == ST_WRITE) ? r_merge : mem_rdata;

  lsu_lane_mux u_lane_mux (
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr[1:0]),
    .i_word    (w_word),
    .i_wdata   (r_wdata),
    .o_load    (w_load),
    .o_merged  (w_merged)
  );

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

  // Memory strobes decode from registered state only
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      ST_LOAD, ST_RMW_RD: begin
        mem_read = 1'b1;
        mem_addr = {r_addr[XLEN-1:2], 2'b00};
      end
      ST_WRITE: begin
        mem_write = r_we;
        mem_addr  = {r_addr[XLEN-1:2], 2'b00};
        mem_wdata = w_merged;
      end
      default: ;
    endcase
  end

  // Request FSM with registered response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_funct3    <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_merge     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            if (w_req_err) begin
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RESP;
            end else if (!req_we) begin
              r_state <= ST_LOAD;
            end else if (req_funct3 == F3_W) begin
              r_state <= ST_WRITE;
            end else begin
              r_state <= ST_RMW_RD;
            end
          end
        end
        ST_LOAD: begin
          r_rsp_rdata <= w_load;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RMW_RD: begin
          r_merge <= mem_rdata;
          r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  load_store_unit #(.MEM_WORDS(256), .XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  // Memory: async read, write on the edge leaving a mem_write cycle
  assign mem_rdata = mem_read ? mem[mem_addr[9:2]] : 32'hDEAD_BEEF;
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    int          reads;
    int          writes;
    logic        chk_mem;
    logic [7:0]  widx;
    logic [31:0] mword;
  } exp_t;

  exp_t q[$];
  int   n_reads = 0;
  int   n_writes = 0;

  // Monitor: counts memory strobes and scores each response pulse
  always @(negedge clk) begin
    if (!rst_n) begin
      n_reads  = 0;
      n_writes = 0;
    end else begin
      if (mem_read)  n_reads++;
      if (mem_write) n_writes++;
      if ((mem_read || mem_write) && mem_addr[1:0] != 2'b00)
        check("mem_addr_align", mem_addr, {mem_addr[31:2], 2'b00});
      if (rsp_valid) begin
        if (q.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check({e.tag, "_rdata"}, rsp_rdata, e.rdata);
          check({e.tag, "_err"}, 32'(rsp_err), 32'(e.err));
          check({e.tag, "_lat"}, 32'(cyc - e.acc + 1), 32'(e.lat));
          check({e.tag, "_reads"}, 32'(n_reads), 32'(e.reads));
          check({e.tag, "_writes"}, 32'(n_writes), 32'(e.writes));
          if (e.chk_mem) check({e.tag, "_mem"}, mem[e.widx], e.mword);
        end
        n_reads  = 0;
        n_writes = 0;
      end
    end
  end

  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic bad;
    if (we) bad = f3[2] || (f3 == 3'b011);
    else    bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    if (a > 32'h3FF) bad = 1'b1;
`ifdef LSU_MISALIGN_CHK_EN
    if ((f3 == 3'b001 || f3 == 3'b101) && a[0]) bad = 1'b1;
    if (f3 == 3'b010 && a[1:0] != 2'b00) bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * a[1:0])) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return b[7]  ? (b | 32'hFFFFFF00) : b;
      3'b001:  return h[15] ? (h | 32'hFFFF0000) : h;
      3'b010:  return w;
      3'b100:  return b;
      3'b101:  return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] w, input logic [31:0] d);
    int unsigned sh;
    if (f3 == 3'b000) begin
      sh = 8 * a[1:0];
      return (w & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
    end else if (f3 == 3'b001) begin
      sh = 16 * a[1];
      return (w & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
    end
    return d;
  endfunction

  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    logic [7:0] idx;
    idx = a[9:2];
    e.tag = tag;
    e.err = model_err(we, f3, a);
    e.chk_mem = 1'b0;
    e.widx = idx;
    e.mword = 32'h0;
    e.rdata = 32'h0;
    if (e.err) begin
      e.lat = 1; e.reads = 0; e.writes = 0;
    end else if (!we) begin
      e.lat = 2; e.reads = 1; e.writes = 0;
      e.rdata = model_load(f3, a, ref_mem[idx]);
    end else begin
      e.lat = (f3 == 3'b010) ? 2 : 3;
      e.reads = (f3 == 3'b010) ? 0 : 1;
      e.writes = 1;
      ref_mem[idx] = model_store(f3, a, ref_mem[idx], d);
      e.chk_mem = 1'b1;
      e.mword = ref_mem[idx];
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    if (!req_ready) begin
      check({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    e.acc = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      check({tag, "_rsp_timeout"}, 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h0100_0000 * i + 32'h00A5_5A00 + i;
    end
    mem[4] = 32'h8899AABB;
    mem[8] = 32'h11223344;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;

    do_req("lb_11",  1'b0, 3'b000, 32'h11, 32'h0);
    do_req("lhu_12", 1'b0, 3'b101, 32'h12, 32'h0);
    do_req("lh_12",  1'b0, 3'b001, 32'h12, 32'h0);
    do_req("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0);
    do_req("lw_10",  1'b0, 3'b010, 32'h10, 32'h0);
    do_req("sb_23",  1'b1, 3'b000, 32'h23, 32'hDEADBE55);
    do_req("lw_20",  1'b0, 3'b010, 32'h20, 32'h0);
    do_req("sh_22",  1'b1, 3'b001, 32'h22, 32'h1234CAFE);
    do_req("sw_24",  1'b1, 3'b010, 32'h24, 32'hA5A5F00F);
    do_req("sw_400", 1'b1, 3'b010, 32'h400, 32'h12345678);
    do_req("lw_top", 1'b0, 3'b010, 32'hFFFFFFFC, 32'h0);
    do_req("sw_3fc", 1'b1, 3'b010, 32'h3FC, 32'h0BADF00D);
    do_req("lw_3fc", 1'b0, 3'b010, 32'h3FC, 32'h0);
    do_req("ld_f011", 1'b0, 3'b011, 32'h10, 32'h0);
    do_req("ld_f110", 1'b0, 3'b110, 32'h10, 32'h0);
    do_req("st_f100", 1'b1, 3'b100, 32'h10, 32'h0);
    do_req("lw_22",  1'b0, 3'b010, 32'h22, 32'h0);
    do_req("lh_13",  1'b0, 3'b001, 32'h13, 32'h0);
    do_req("sh_31",  1'b1, 3'b001, 32'h31, 32'h00007788);
    do_req("lw_30",  1'b0, 3'b010, 32'h30, 32'h0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = (n % 9 == 8) ? (32'h400 + $urandom_range(0, 64)) : 32'($urandom_range(0, 255));
      do_req("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end

    // Reset during the WRITE phase of an SH
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h20; req_wdata = 32'hCAFE1234;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 check("abort_in_write", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1 check("abort_write_drop", 32'(mem_write), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    check("abort_mem", mem[8], ref_mem[8]);
    do_req("lw_20_post", 1'b0, 3'b010, 32'h20, 32'h0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute stage and the unified instruction/data memory.
- Turns RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into the memory's word-only data interface.
- Loads: selects the addressed byte/halfword and sign- or zero-extends it.
- SB/SH: read-modify-write on the containing word.
- Stalls the core through a valid/ready handshake and reports illegal accesses.

Parameters:
- MEM_WORDS, 256: memory depth in 32-bit words. A byte address ≥ MEM_WORDS*4 is out of range.
- XLEN, 32: data and address width. Only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core presents an access
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 of the load/store
- req_addr  in  32  byte address (rs1 + imm)
- req_wdata  in  32  store data (rs2)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load result; 0 for stores and errors
- rsp_err  out  1  access rejected, no memory side-effect; valid with rsp_valid
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_addr  out  32  word-aligned byte address to memory (low 2 bits always 0)
- mem_wdata  out  32  to memory data_in
- mem_rdata  in  32  from memory data_out; high-Z unless mem_read=1

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: state IDLE; rsp_valid=0, rsp_err=0, rsp_rdata=0; mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0; internal request and merge registers = 0.
- Handshake: a request is accepted on a rising edge where req_valid && req_ready. Accepting latches we, funct3, addr and wdata. The core holds its request until accepted.
- Error conditions (no memory access):
  - Load funct3 ∈ {011, 110, 111}.
  - Store funct3 ∈ {011, 1xx}.
  - Address out of range.
  - Misaligned access (see Optional Feature).
- FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE transitions:
  - error → RESP with err latched.
  - load → LOAD.
  - SW → WRITE.
  - SB/SH → RMW_RD.
- LOAD: mem_read=1, mem_addr={addr[31:2],2'b00}. Extracted value is registered into rsp_rdata. Next state RESP.
- Load extraction:
  - Byte lane k = addr[1:0], bits [8k+7:8k], little-endian.
  - Halfword = addr[1] ? [31:16] : [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- RMW_RD: mem_read=1. mem_rdata is registered into the merge buffer. Next state WRITE.
- WRITE: mem_write=1; memory commits on the edge leaving WRITE. Next state RESP.
  - SW: mem_wdata = wdata.
  - SB: mem_wdata = merge buffer with lane addr[1:0] replaced by wdata[7:0].
  - SH: mem_wdata = merge buffer with the half selected by addr[1] replaced by wdata[15:0].
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. req_ready stays 0, so a new request is accepted earliest on the edge after RESP.
- Latency (accept edge to rsp_valid high), all with no bubbles beyond these:
  - error: 1 cycle
  - load, SW: 2 cycles
  - SB/SH: 3 cycles
- Output decoding: mem_read, mem_write, mem_addr and mem_wdata decode from registered state only (no path from req_*). mem_addr=0 and mem_wdata=0 outside LOAD/RMW_RD/WRITE.
- Reset mid-operation: returns to IDLE immediately. A pending WRITE is dropped, so memory is unchanged. No rsp_valid is generated for the aborted request.
- Address 0xFFFFFFFC with MEM_WORDS=256: range error. No wrap-around into low memory.

Optional Feature:
- Macro: LSU_MISALIGN_CHK_EN.
- Defined: any of these is an error (rsp_err=1, no memory access):
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]≠0.
- Undefined: misaligned low bits are ignored.
  - Halfword uses addr[1] only.
  - Word uses addr[31:2].
  - Access proceeds normally; funct3 and range errors are still reported.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - The FSM state encoding.
- One sub-module, lsu_lane_mux, purely combinational:
  - Load extract/extend.
  - Store merge from (funct3, addr[1:0], word, wdata).
- FSM and registers live in load_store_unit.

Test Plan:
- Memory word 0x10 = 0x8899AABB; LB addr 0x11 → rsp_valid 2 cycles after accept, rsp_rdata=0xFFFFFFAA, rsp_err=0.
- Same word; LHU addr 0x12 → rsp_rdata=0x00008899. LH addr 0x12 → 0xFFFF8899.
- Word 0x20 = 0x11223344; SB addr 0x23 wdata 0xDEADBE55 → one RMW_RD then one WRITE cycle, memory 0x20 = 0x55223344, rsp_valid 3 cycles after accept.
- SW addr 0x400 with MEM_WORDS=256 → rsp_err=1 one cycle after accept, mem_write never asserted.
- With LSU_MISALIGN_CHK_EN: LW addr 0x22 → rsp_err=1. Without it: LW addr 0x22 returns word 0x20.
- Assert rst_n low during WRITE of SH addr 0x20 → memory unchanged, no rsp_valid, req_ready=1 in the first cycle after rst_n deasserts.
